pipelined_window_summator: RTL and testbench

Parametrised pipelined accumulator that sums a fixed-size window of input samples and emits one result per window. It generalises the fixed 13-bit-in / 21-bit-out summator with these additions:
- configurable widths and window length;
- signed mode;
- a segmented, carry-pipelined adder;
- an explicit result-valid pulse and an overflow flag.

It sits at the output of sample-producing datapath blocks and feeds averaging/decimation logic.

---
 rtl/pipelined_window_summator.sv | 143 ++++++++++++++
 tb/tb_pipelined_window_summator.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_window_summator.sv
// Window summator: adds WIN accepted samples through a SEG-way carry-pipelined adder.
// Y, ovf and a one-cycle y_valid appear SEG+1 cycles after the closing sample; never stalls.
module pipelined_window_summator #(
  parameter int IN_W   = 13,
  parameter int ACC_W  = 21,
  parameter int SEG    = 2,
  parameter int WIN    = 256,
  parameter bit SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic [IN_W-1:0]  A,
  output logic [ACC_W-1:0] Y,
  output logic             y_valid,
  output logic             ovf
);
  localparam int SW = (ACC_W + SEG - 1) / SEG;
  localparam int TW = ACC_W - (SEG - 1) * SW;
  localparam int CW = (WIN > 1) ? $clog2(WIN) : 1;

  logic [CW-1:0]    cnt;
  logic [ACC_W-1:0] a_ext;
  logic             first_in;
  logic             last_in;
  logic [SEG-1:0]   first_q;
  logic [SEG-1:0]   last_q;
  logic [SEG-1:0]   cin;
  logic [ACC_W-1:0] y_deskew;
  logic             ov_now;
  logic             ovf_acc;
  logic             pend;

  always_comb begin
    a_ext = '0;
    if (ce) begin
      if (SIGNED) a_ext = ACC_W'($signed(A));
      else        a_ext = ACC_W'(A);
    end
  end

  assign first_in = ce && (cnt == '0);
  assign last_in  = ce && (cnt == CW'(WIN - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (ce) begin
      cnt <= last_in ? '0 : cnt + CW'(1);
    end
  end

  // Window markers travel with the sample so each segment sees its boundary in its own cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      first_q <= '0;
      last_q  <= '0;
    end else begin
      first_q[0] <= first_in;
      last_q[0]  <= last_in;
      for (int i = 1; i < SEG; i++) begin
        first_q[i] <= first_q[i-1];
        last_q[i]  <= last_q[i-1];
      end
    end
  end

  assign cin[0] = 1'b0;

  for (genvar s = 0; s < SEG; s++) begin : g_seg
    localparam int LO = s * SW;
    localparam int W  = (s == SEG - 1) ? TW : SW;
    localparam int D  = SEG - 1 - s;

    logic [W-1:0] ad [s+1];
    logic [W-1:0] acc;
    logic [W-1:0] base;
    logic [W:0]   sum;

    assign base = first_q[s] ? '0 : acc;
    assign sum  = {1'b0, base} + {1'b0, ad[s]} + {{W{1'b0}}, cin[s]};

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i <= s; i++) ad[i] <= '0;
        acc <= '0;
      end else begin
        ad[0] <= a_ext[LO +: W];
        for (int i = 1; i <= s; i++) ad[i] <= ad[i-1];
        acc <= sum[W-1:0];
      end
    end

    if (s < SEG - 1) begin : g_cry
      logic cry;
      always_ff @(posedge clk) begin
        if (rst) cry <= 1'b0;
        else     cry <= sum[W];
      end
      assign cin[s+1] = cry;
    end else begin : g_top
      if (SIGNED) begin : g_sovf
        assign ov_now = (base[W-1] == ad[s][W-1]) && (sum[W-1] != ad[s][W-1]);
      end else begin : g_uovf
        assign ov_now = sum[W];
      end
    end

    // Lower segments finish earlier; delay them so all slices of one window line up.
    if (D == 0) begin : g_nd
      assign y_deskew[LO +: W] = acc;
    end else begin : g_d
      logic [W-1:0] sh [D];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < D; i++) sh[i] <= '0;
        end else begin
          sh[0] <= acc;
          for (int i = 1; i < D; i++) sh[i] <= sh[i-1];
        end
      end
      assign y_deskew[LO +: W] = sh[D-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_acc <= 1'b0;
      pend    <= 1'b0;
      Y       <= '0;
      y_valid <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      ovf_acc <= (first_q[SEG-1] ? 1'b0 : ovf_acc) | ov_now;
      pend    <= last_q[SEG-1];
      y_valid <= pend;
      if (pend) begin
        Y   <= y_deskew;
        ovf <= ovf_acc;
      end
    end
  end
endmodule

// File: tb/tb_pipelined_window_summator.sv
// Six configurations share one stimulus stream; a per-instance model predicts each
// result, its overflow flag and the edge it must appear on.
module tb_pipelined_window_summator;
  localparam int NI = 6;
  localparam int ACCW [NI] = '{21, 21, 21, 21, 14, 16};
  localparam int WINS [NI] = '{256, 256, 256, 256, 4, 4};
  localparam bit SGN  [NI] = '{0, 0, 0, 0, 0, 1};
  localparam int LATS [NI] = '{3, 2, 4, 5, 3, 3};

  typedef struct {
    logic [63:0] y;
    logic        ov;
    int          due;
  } exp_t;

  typedef struct {
    logic [12:0] a;
    logic [12:0] a_idle;
    bit          alt;
    int          n;
    logic [63:0] exp_y;
    int          exp_p;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        ce;
  logic [12:0] a;
  logic [20:0] y0, y1, y2, y3;
  logic [13:0] y4;
  logic [15:0] y5;
  logic [NI-1:0] v;
  logic [NI-1:0] o;

  int checks = 0;
  int failures = 0;
  int edge_n = 0;
  int pulses [NI];
  logic [63:0] last_y [NI];
  logic last_o [NI];
  longint m_sum [NI];
  bit m_ovf [NI];
  int m_cnt [NI];
  exp_t exp_q [NI][$];
  vec_t tbl [3];

  pipelined_window_summator #(.SEG(2)) u0 (.clk(clk), .rst(rst), .ce(ce), .A(a), .Y(y0), .y_valid(v[0]), .ovf(o[0]));
  pipelined_window_summator #(.SEG(1)) u1 (.clk(clk), .rst(rst), .ce(ce), .A(a), .Y(y1), .y_valid(v[1]), .ovf(o[1]));
  pipelined_window_summator #(.SEG(3)) u2 (.clk(clk), .rst(rst), .ce(ce), .A(a), .Y(y2), .y_valid(v[2]), .ovf(o[2]));
  pipelined_window_summator #(.SEG(4)) u3 (.clk(clk), .rst(rst), .ce(ce), .A(a), .Y(y3), .y_valid(v[3]), .ovf(o[3]));
  pipelined_window_summator #(.ACC_W(14), .WIN(4), .SIGNED(1'b0)) u4 (
    .clk(clk), .rst(rst), .ce(ce), .A(a), .Y(y4), .y_valid(v[4]), .ovf(o[4]));
  pipelined_window_summator #(.ACC_W(16), .WIN(4), .SIGNED(1'b1)) u5 (
    .clk(clk), .rst(rst), .ce(ce), .A(a), .Y(y5), .y_valid(v[5]), .ovf(o[5]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] get_y(int i);
    case (i)
      0: return 64'(y0);
      1: return 64'(y1);
      2: return 64'(y2);
      3: return 64'(y3);
      4: return 64'(y4);
      default: return 64'(y5);
    endcase
  endfunction

  task automatic chk(string nm, int inst, logic [63:0] act, logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s inst=%0d edge=%0d actual=%0h required=%0h", nm, inst, edge_n, act, expv);
    end
  endtask

  task automatic monitor();
    exp_t e;
    for (int i = 0; i < NI; i++) begin
      if (v[i] === 1'b1) begin
        pulses[i]++;
        last_y[i] = get_y(i);
        last_o[i] = o[i];
        if (exp_q[i].size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_pulse inst=%0d edge=%0d actual=%0h required=no pulse", i, edge_n, get_y(i));
        end else begin
          e = exp_q[i].pop_front();
          chk("y", i, get_y(i), e.y);
          chk("ovf", i, 64'(o[i]), 64'(e.ov));
          chk("pulse_edge", i, 64'(edge_n), 64'(e.due));
        end
      end
    end
  endtask

  task automatic model_step(input logic r, input logic c, input logic [12:0] d);
    longint mask, half, e, sv, t;
    for (int i = 0; i < NI; i++) begin
      if (r) begin
        m_sum[i] = 0;
        m_ovf[i] = 0;
        m_cnt[i] = 0;
        exp_q[i].delete();
      end else if (c) begin
        mask = (longint'(1) << ACCW[i]) - 1;
        e = SGN[i] ? longint'($signed(d)) : longint'(d);
        if (SGN[i]) begin
          half = longint'(1) << (ACCW[i] - 1);
          sv = (m_sum[i] >= half) ? m_sum[i] - (mask + 1) : m_sum[i];
          t = sv + e;
          if (t >= half || t < -half) m_ovf[i] = 1;
        end else if (m_sum[i] + e > mask) begin
          m_ovf[i] = 1;
        end
        m_sum[i] = (m_sum[i] + e) & mask;
        m_cnt[i]++;
        if (m_cnt[i] == WINS[i]) begin
          exp_q[i].push_back('{y: 64'(m_sum[i]), ov: m_ovf[i], due: edge_n + LATS[i]});
          m_sum[i] = 0;
          m_ovf[i] = 0;
          m_cnt[i] = 0;
        end
      end
    end
  endtask

  task automatic drive(input logic r, input logic c, input logic [12:0] d);
    @(negedge clk);
    monitor();
    rst = r;
    ce = c;
    a = d;
    @(posedge clk);
    edge_n++;
    model_step(r, c, d);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 13'h1FFF);
  endtask

  task automatic burst(input int n, input logic [12:0] d);
    for (int k = 0; k < n; k++) drive(1'b0, 1'b1, d);
  endtask

  task automatic do_reset(input int n);
    for (int k = 0; k < n; k++) drive(1'b1, 1'b1, 13'h0AAA);
    #1;
    chk("rst_y", 0, 64'(y0), 64'd0);
    chk("rst_vld", 0, 64'(v[0]), 64'd0);
    chk("rst_ovf", 0, 64'(o[0]), 64'd0);
    chk("rst_y", 4, 64'(y4), 64'd0);
    chk("rst_ovf", 4, 64'(o[4]), 64'd0);
    for (int i = 0; i < NI; i++) pulses[i] = 0;
  endtask

  initial begin
    rst = 1'b1;
    ce = 1'b0;
    a = '0;
    for (int i = 0; i < NI; i++) begin
      pulses[i] = 0;
      last_y[i] = '0;
      last_o[i] = 1'b0;
      m_sum[i] = 0;
      m_ovf[i] = 0;
      m_cnt[i] = 0;
    end
    tbl[0] = '{a: 13'd1,    a_idle: 13'd0,    alt: 1'b0, n: 256, exp_y: 64'd256,     exp_p: 1};
    tbl[1] = '{a: 13'd8191, a_idle: 13'd0,    alt: 1'b0, n: 256, exp_y: 64'h1FFF00,  exp_p: 1};
    tbl[2] = '{a: 13'd1,    a_idle: 13'h1FFF, alt: 1'b1, n: 512, exp_y: 64'd256,     exp_p: 1};

    foreach (tbl[t]) begin
      do_reset(2);
      for (int j = 0; j < tbl[t].n; j++) begin
        if (tbl[t].alt && j[0]) drive(1'b0, 1'b0, tbl[t].a_idle);
        else                    drive(1'b0, 1'b1, tbl[t].a);
      end
      idle(8);
      for (int i = 0; i < 4; i++) begin
        chk("tbl_pulses", i, 64'(pulses[i]), 64'(tbl[t].exp_p));
        chk("tbl_y", i, last_y[i], tbl[t].exp_y);
        chk("tbl_ovf", i, 64'(last_o[i]), 64'd0);
      end
    end

    // Back-to-back windows with a value change at the boundary.
    do_reset(2);
    burst(512, 13'd1);
    burst(256, 13'd3);
    idle(8);
    chk("b2b_pulses", 0, 64'(pulses[0]), 64'd3);
    chk("b2b_y", 0, last_y[0], 64'd768);

    // Reset mid-window discards the partial sum.
    do_reset(2);
    burst(100, 13'd5);
    drive(1'b1, 1'b0, 13'd0);
    burst(256, 13'd2);
    idle(8);
    chk("midrst_pulses", 0, 64'(pulses[0]), 64'd1);
    chk("midrst_y", 0, last_y[0], 64'd512);

    // Reset while the closed window is draining: no pulse for it.
    do_reset(2);
    burst(256, 13'd2);
    drive(1'b1, 1'b0, 13'd0);
    for (int i = 0; i < NI; i++) pulses[i] = 0;
    idle(8);
    chk("drain_rst_pulses", 0, 64'(pulses[0]), 64'd0);
    chk("drain_rst_pulses", 3, 64'(pulses[3]), 64'd0);

    // Overflow: unsigned wrap, signed in-range negative sum, and flag cleared next window.
    do_reset(2);
    burst(4, 13'd8191);
    idle(6);
    chk("ovf_u_y", 4, last_y[4], 64'd16380);
    chk("ovf_u_flag", 4, 64'(last_o[4]), 64'd1);
    do_reset(2);
    burst(4, 13'h1000);
    idle(6);
    chk("ovf_s_y", 5, last_y[5], 64'hC000);
    chk("ovf_s_flag", 5, 64'(last_o[5]), 64'd0);
    burst(4, 13'd1);
    idle(6);
    chk("ovf_clear_y", 4, last_y[4], 64'd4);
    chk("ovf_clear_flag", 4, 64'(last_o[4]), 64'd0);

    idle(10);
    for (int i = 0; i < NI; i++) chk("missing_pulse", i, 64'(exp_q[i].size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
